branch_resolve_ctrl: RTL and testbench

- Sequences branch/jump resolution for the 5-stage pipeline.
- Holds an in-order queue of predictions issued at ID (pc, predicted direction, predicted target) and checks each one against the EX resolution.
- On a mispredict: raises flush for a fixed window, issues a one-shot PC redirect, and squashes younger queue entries.
- Drives in-order update pulses to the gshare predictor and stalls fetch when the queue is full.

---
 rtl/branch_resolve_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - in-order branch prediction queue with mispredict flush/redirect and predictor update
// Optional perf counters (resolved_cnt, mispred_cnt) are built when BRQ_PERF_CNT_EN is defined.
module branch_resolve_ctrl #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_W         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pred_valid,
  input  logic [PC_W-1:0] pred_pc,
  input  logic            pred_taken,
  input  logic [PC_W-1:0] pred_target,
  input  logic            res_valid,
  input  logic            res_taken,
  input  logic [PC_W-1:0] res_target,
  output logic            stall_fe,
  output logic            flush,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            upd_valid,
  output logic [7:0]      upd_pc,
  output logic            upd_taken,
  output logic            err_underflow
`ifdef BRQ_PERF_CNT_EN
  ,
  output logic [31:0]     resolved_cnt,
  output logic [31:0]     mispred_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [2:0]    FLUSH_LEN = 3'(FLUSH_CYCLES);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [2:0]      r_flush_cnt;
  logic            r_flush;
  logic            r_redirect_valid;
  logic [PC_W-1:0] r_redirect_pc;
  logic            r_upd_valid;
  logic [7:0]      r_upd_pc;
  logic            r_upd_taken;
  logic            r_err_underflow;

  logic [PC_W-1:0] r_pc_mem     [DEPTH];
  logic            r_taken_mem  [DEPTH];
  logic [PC_W-1:0] r_target_mem [DEPTH];

  logic            w_full;
  logic            w_run;
  logic            w_deq;
  logic            w_enq;
  logic            w_push;
  logic [PC_W-1:0] w_head_pc;
  logic            w_head_taken;
  logic [PC_W-1:0] w_head_target;
  logic            w_mispred;
  logic [PC_W-1:0] w_corr_pc;

  assign w_full        = (r_count == FULL_CNT);
  assign w_run         = (r_state == S_RUN);
  assign w_deq         = w_run && res_valid && (r_count != '0);
  assign w_enq         = w_run && pred_valid && (!w_full || w_deq);
  assign w_head_pc     = r_pc_mem[r_rd_ptr];
  assign w_head_taken  = r_taken_mem[r_rd_ptr];
  assign w_head_target = r_target_mem[r_rd_ptr];
  assign w_mispred     = (res_taken != w_head_taken) ||
                         (res_taken && (res_target != w_head_target));
  assign w_corr_pc     = res_taken ? res_target : (w_head_pc + PC_W'(4));
  // A same-cycle enqueue is younger than a mispredicting head, so it is squashed.
  assign w_push        = w_enq && !(w_deq && w_mispred);

  assign stall_fe       = w_full;
  assign flush          = r_flush;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign upd_valid      = r_upd_valid;
  assign upd_pc         = r_upd_pc;
  assign upd_taken      = r_upd_taken;
  assign err_underflow  = r_err_underflow;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]     <= pred_pc;
      r_taken_mem[r_wr_ptr]  <= pred_taken;
      r_target_mem[r_wr_ptr] <= pred_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= S_RUN;
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
      r_count          <= '0;
      r_flush_cnt      <= '0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_upd_valid      <= 1'b0;
      r_upd_pc         <= '0;
      r_upd_taken      <= 1'b0;
      r_err_underflow  <= 1'b0;
    end else begin
      r_upd_valid      <= 1'b0;
      r_redirect_valid <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (res_valid && (r_count == '0)) begin
            r_err_underflow <= 1'b1;
          end
          if (w_deq) begin
            r_upd_valid <= 1'b1;
            r_upd_pc    <= w_head_pc[7:0];
            r_upd_taken <= res_taken;
          end
          if (w_deq && w_mispred) begin
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= w_corr_pc;
            r_rd_ptr         <= '0;
            r_wr_ptr         <= '0;
            r_count          <= '0;
            r_state          <= S_FLUSH;
            r_flush          <= 1'b1;
            r_flush_cnt      <= FLUSH_LEN;
          end else begin
            if (w_deq) begin
              r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_enq) begin
              r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            case ({w_enq, w_deq})
              2'b10:   r_count <= r_count + CW'(1);
              2'b01:   r_count <= r_count - CW'(1);
              default: r_count <= r_count;
            endcase
          end
        end
        S_FLUSH: begin
          r_flush_cnt <= r_flush_cnt - 3'd1;
          if (r_flush_cnt <= 3'd1) begin
            r_flush <= 1'b0;
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

`ifdef BRQ_PERF_CNT_EN
  logic [31:0] r_resolved_cnt;
  logic [31:0] r_mispred_cnt;

  assign resolved_cnt = r_resolved_cnt;
  assign mispred_cnt  = r_mispred_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_resolved_cnt <= '0;
      r_mispred_cnt  <= '0;
    end else begin
      if (w_deq && (r_resolved_cnt != '1)) begin
        r_resolved_cnt <= r_resolved_cnt + 32'd1;
      end
      if (w_deq && w_mispred && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - scoreboard bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;
  localparam int PC_W  = 32;
  localparam int DEPTH = 4;
  localparam int FC    = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            pred_valid, pred_taken, res_valid, res_taken;
  logic [PC_W-1:0] pred_pc, pred_target, res_target;
  logic            stall_fe, flush, redirect_valid, upd_valid, upd_taken, err_underflow;
  logic [PC_W-1:0] redirect_pc;
  logic [7:0]      upd_pc;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .stall_fe(stall_fe), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .err_underflow(err_underflow)
  );

  typedef struct {logic [7:0] pc8; logic tk; logic rd; logic [31:0] rpc;} exp_t;
  typedef struct {logic [31:0] pc; logic tk; logic [31:0] tg;} ent_t;

  exp_t exp_q[$];
  ent_t mq[$];
  int   m_flush = 0;
  logic m_err = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step(input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] ptg,
                      input logic rv, input logic rt, input logic [31:0] rtg);
    logic was_full, in_fl, deq, mis;
    ent_t e;
    exp_t x;
    chk("stall_fe", stall_fe, (m_flush == 0 && mq.size() == DEPTH));
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_taken = rt; res_target = rtg;
    was_full = (mq.size() == DEPTH);
    in_fl = (m_flush > 0);
    deq = 1'b0;
    mis = 1'b0;
    if (!in_fl && rv) begin
      if (mq.size() == 0) m_err = 1'b1;
      else begin
        deq = 1'b1;
        e = mq.pop_front();
        mis = (rt != e.tk) || (rt && rtg != e.tg);
        x.pc8 = e.pc[7:0];
        x.tk  = rt;
        x.rd  = mis;
        x.rpc = rt ? rtg : e.pc + 32'd4;
        exp_q.push_back(x);
      end
    end
    if (in_fl) m_flush--;
    else if (mis) begin
      mq.delete();
      m_flush = FC;
    end else if (pv && (!was_full || deq)) mq.push_back('{ppc, pt, ptg});
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    chk("flush", flush, m_flush > 0);
    chk("err_underflow", err_underflow, m_err);
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("upd_valid", upd_valid, 1);
      chk("upd_pc", upd_pc, x.pc8);
      chk("upd_taken", upd_taken, x.tk);
      chk("redirect_valid", redirect_valid, x.rd);
      if (x.rd) chk("redirect_pc", redirect_pc, x.rpc);
    end else begin
      chk("upd_valid_idle", upd_valid, 0);
      chk("redirect_valid_idle", redirect_valid, 0);
    end
  endtask

  task automatic pred(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    step(1'b1, pc, tk, tg, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic resolve(input logic tk, input logic [31:0] tg);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, tk, tg);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_target = '0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flush", flush, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_upd", upd_valid, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_stall", stall_fe, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // correct prediction
    pred(32'h100, 1'b1, 32'h140);
    resolve(1'b1, 32'h140);
    idle();

    // not-taken predicted, taken actual; predictions during flush are dropped
    pred(32'h200, 1'b0, 32'h0);
    resolve(1'b1, 32'h180);
    pred(32'h210, 1'b0, 32'h0);
    pred(32'h214, 1'b0, 32'h0);
    idle();

    // taken predicted, not-taken actual, younger enqueue squashed
    pred(32'h300, 1'b1, 32'h340);
    step(1'b1, 32'h30C, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    idle();
    idle();
    resolve(1'b0, 32'h0);

    // fill, drop, accept-at-full, then drain across pointer wrap
    for (int i = 0; i < DEPTH; i++) pred(32'h400 + 32'(i * 4), 1'b0, 32'h0);
    pred(32'h4F0, 1'b0, 32'h0);
    step(1'b1, 32'h410, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < DEPTH; i++) resolve(1'b0, 32'h0);
    idle();

    // taken with wrong target
    pred(32'h500, 1'b1, 32'h520);
    resolve(1'b1, 32'h530);
    idle();
    idle();

    // reset asserted during the second flush cycle
    pred(32'h600, 1'b0, 32'h0);
    resolve(1'b1, 32'h640);
    idle();
    rst = 1'b0;
    #1;
    chk("async_rst_flush", flush, 0);
    chk("async_rst_redirect", redirect_valid, 0);
    chk("async_rst_err", err_underflow, 0);
    chk("async_rst_stall", stall_fe, 0);
    mq.delete();
    exp_q.delete();
    m_flush = 0;
    m_err = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    pred(32'h700, 1'b1, 32'h720);
    resolve(1'b1, 32'h720);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
